// File: rtl/audio_dac_serializer_if.sv
// audio_dac_serializer_if: sample push port of the I2S DAC serializer.
// The producer (master) offers one stereo pair per clk with 'write'; the
// serializer (slave) accepts it whenever 'write_ready' is high.
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 24
);

  logic                  write;
  logic [DATA_WIDTH-1:0] writedata_left;
  logic [DATA_WIDTH-1:0] writedata_right;
  logic                  write_ready;

  modport master (
    output write,
    output writedata_left,
    output writedata_right,
    input  write_ready
  );

  modport slave (
    input  write,
    input  writedata_left,
    input  writedata_right,
    output write_ready
  );

endinterface

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: stereo sample FIFO feeding an I2S DAC data line.
//
// Pairs are pushed in the clk domain. The codec's bit clock (AUD_BCLK) and
// frame clock (AUD_DACLRCK) are asynchronous; both go through identical
// 2-flop synchronisers and an edge-detect register so their edges line up
// exactly, three clk after the pin transition.
//
// Each LRCK falling edge starts a left slot: a pair is popped (or a fallback
// pair is used when the FIFO is empty, flagging a sticky underflow). The
// right sample waits in a staging register until the LRCK rising edge.
// Within a slot the first BCLK fall is the I2S one-bit delay, then the
// sample goes out MSB first, then the line idles at 0 until the next edge.
//
// Optional build macro DAC_UNDERFLOW_HOLD_EN: on underflow, replay the most
// recently popped pair instead of emitting silence (0/0).
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  audio_dac_serializer_if.slave         bus,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO_C = CW'(0);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BIT_ZERO_C = BW'(0);
  localparam logic [BW-1:0] BIT_ONE_C  = BW'(1);
  localparam logic [BW-1:0] LAST_BIT_C = BW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SHIFT = 2'd2,
    ST_PAD   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Codec clock synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] bclk_sync_r;
  logic [1:0] lrck_sync_r;
  logic       bclk_prev_r;
  logic       lrck_prev_r;
  logic       bclk_fall_s;
  logic       lrck_fall_s;
  logic       lrck_rise_s;

  // Bring BCLK/LRCK into clk through matching 2-flop chains plus one history flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_r <= 2'b00;
      lrck_sync_r <= 2'b00;
      bclk_prev_r <= 1'b0;
      lrck_prev_r <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[0], AUD_BCLK};
      lrck_sync_r <= {lrck_sync_r[0], AUD_DACLRCK};
      bclk_prev_r <= bclk_sync_r[1];
      lrck_prev_r <= lrck_sync_r[1];
    end
  end

  // Everything resets to 0, so no edge can be seen the first cycle after release.
  assign bclk_fall_s = bclk_prev_r & ~bclk_sync_r[1];
  assign lrck_fall_s = lrck_prev_r & ~lrck_sync_r[1];
  assign lrck_rise_s = ~lrck_prev_r & lrck_sync_r[1];

  // ---------------------------------------------------------------------------
  // Stereo pair FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_left_r  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_right_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  write_ready_r;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] rd_left_s;
  logic [DATA_WIDTH-1:0] rd_right_s;

  // Decode push/pop and the resulting occupancy for this cycle
  always_comb begin
    push_s      = bus.write & write_ready_r;
    pop_s       = lrck_fall_s & (count_r != CNT_ZERO_C);
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + CNT_ONE_C;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CNT_ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Sample storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_left_r[wr_ptr_r]  <= bus.writedata_left;
      mem_right_r[wr_ptr_r] <= bus.writedata_right;
    end
  end

  // Pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= CNT_ZERO_C;
      write_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      count_r       <= count_nxt_s;
      write_ready_r <= (count_nxt_s < DEPTH_C);
    end
  end

  assign rd_left_s  = mem_left_r[rd_ptr_r];
  assign rd_right_s = mem_right_r[rd_ptr_r];

  // ---------------------------------------------------------------------------
  // Fallback pair used when a frame starts with nothing buffered
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fb_left_s;
  logic [DATA_WIDTH-1:0] fb_right_s;

`ifdef DAC_UNDERFLOW_HOLD_EN
  logic [DATA_WIDTH-1:0] hold_left_r;
  logic [DATA_WIDTH-1:0] hold_right_r;

  // Remember the last popped pair so an underflow repeats it instead of muting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_left_r  <= {DATA_WIDTH{1'b0}};
      hold_right_r <= {DATA_WIDTH{1'b0}};
    end else if (pop_s) begin
      hold_left_r  <= rd_left_s;
      hold_right_r <= rd_right_s;
    end
  end

  assign fb_left_s  = hold_left_r;
  assign fb_right_s = hold_right_r;
`else
  assign fb_left_s  = {DATA_WIDTH{1'b0}};
  assign fb_right_s = {DATA_WIDTH{1'b0}};
`endif

  logic [DATA_WIDTH-1:0] load_left_s;
  logic [DATA_WIDTH-1:0] load_right_s;

  // Choose what a left-slot start loads: fresh FIFO data or the fallback pair
  always_comb begin
    load_left_s  = fb_left_s;
    load_right_s = fb_right_s;
    if (pop_s) begin
      load_left_s  = rd_left_s;
      load_right_s = rd_right_s;
    end else begin
      load_left_s  = fb_left_s;
      load_right_s = fb_right_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot sequencer and serialiser
  // ---------------------------------------------------------------------------
  state_t                state_r;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [DATA_WIDTH-1:0] stage_r;
  logic [BW-1:0]         bit_cnt_r;
  logic                  dacdat_r;
  logic                  underflow_r;

  // LRCK edges (re)load a slot and take priority; BCLK falls step the output.
  // A BCLK fall coinciding with an LRCK edge is consumed as the delay bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      shift_r     <= {DATA_WIDTH{1'b0}};
      stage_r     <= {DATA_WIDTH{1'b0}};
      bit_cnt_r   <= BIT_ZERO_C;
      dacdat_r    <= 1'b0;
      underflow_r <= 1'b0;
    end else if (lrck_fall_s) begin
      shift_r   <= load_left_s;
      stage_r   <= load_right_s;
      bit_cnt_r <= BIT_ZERO_C;
      state_r   <= ST_DELAY;
      if (!pop_s) begin
        underflow_r <= 1'b1;
      end
      if (bclk_fall_s) begin
        dacdat_r <= 1'b0;
      end
    end else if (lrck_rise_s && (state_r != ST_IDLE)) begin
      shift_r   <= stage_r;
      bit_cnt_r <= BIT_ZERO_C;
      state_r   <= ST_DELAY;
      if (bclk_fall_s) begin
        dacdat_r <= 1'b0;
      end
    end else if (bclk_fall_s) begin
      case (state_r)
        ST_IDLE: begin
          dacdat_r <= 1'b0;
        end
        ST_DELAY: begin
          dacdat_r  <= shift_r[DATA_WIDTH-1];
          shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
          bit_cnt_r <= BIT_ONE_C;
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt_r == LAST_BIT_C) begin
            dacdat_r <= 1'b0;
            state_r  <= ST_PAD;
          end else begin
            dacdat_r  <= shift_r[DATA_WIDTH-1];
            shift_r   <= {shift_r[DATA_WIDTH-2:0], 1'b0};
            bit_cnt_r <= bit_cnt_r + BIT_ONE_C;
          end
        end
        ST_PAD: begin
          dacdat_r <= 1'b0;
        end
        default: begin
          dacdat_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign AUD_DACDAT      = dacdat_r;
  assign underflow       = underflow_r;
  assign fifo_count      = count_r;
  assign bus.write_ready = write_ready_r;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: randomized self-checking bench for the I2S DAC
// serializer. The reference model is a queue of pushed pairs; each recorded
// slot of serial data is compared against the ideal I2S slot image
// {delay bit 0, sample MSB first, zero padding}.
module tb_audio_dac_serializer;

  localparam int DW        = 24;
  localparam int DEPTH     = 8;
  localparam int SLOT_BITS = 32;
  localparam int CLK_HALF  = 10;
  localparam int BCLK_HALF = 160;

  logic           clk;
  logic           reset_n;
  logic           aud_bclk;
  logic           aud_lrck;
  logic           aud_dacdat;
  logic           underflow;
  logic [3:0]     fifo_count;
  bit             frames_on;

  audio_dac_serializer_if #(.DATA_WIDTH(DW)) dac_bus ();

  audio_dac_serializer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (dac_bus),
    .AUD_BCLK   (aud_bclk),
    .AUD_DACLRCK(aud_lrck),
    .AUD_DACDAT (aud_dacdat),
    .fifo_count (fifo_count),
    .underflow  (underflow)
  );

  int n_checks;
  int n_errors;

  // Reference model state
  logic [DW-1:0] q_left[$];
  logic [DW-1:0] q_right[$];
  logic [DW-1:0] cur_right;
  logic [DW-1:0] hold_left;
  logic [DW-1:0] hold_right;
  bit            started;
  bit            model_uf;
  int            rst_epoch;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // System clock
  initial begin
    clk = 1'b0;
    forever #CLK_HALF clk = ~clk;
  end

  // Codec clocks: 32 BCLK per slot, LRCK toggles on a BCLK fall
  initial begin
    aud_bclk = 1'b0;
    aud_lrck = 1'b0;
    wait (frames_on);
    #7;
    forever begin
      for (int i = 0; i < SLOT_BITS; i++) begin
        #BCLK_HALF aud_bclk = 1'b1;
        #BCLK_HALF aud_bclk = 1'b0;
        if (i == SLOT_BITS - 1) aud_lrck = ~aud_lrck;
      end
    end
  end

  // Slot monitor: decide the expected word at each LRCK edge, record 32 bits
  // at BCLK rises, compare the whole slot image
  always begin : slot_monitor
    logic [SLOT_BITS-1:0] cap;
    logic [SLOT_BITS-1:0] exp_slot;
    logic [DW-1:0]        word;
    int                   epoch;
    bit                   is_left;
    if (!frames_on) wait (frames_on);
    @(aud_lrck);
    epoch   = rst_epoch;
    is_left = (aud_lrck == 1'b0);
    if (is_left) begin
      if (q_left.size() > 0) begin
        word       = q_left.pop_front();
        cur_right  = q_right.pop_front();
        hold_left  = word;
        hold_right = cur_right;
      end else begin
        model_uf = 1'b1;
`ifdef DAC_UNDERFLOW_HOLD_EN
        word      = hold_left;
        cur_right = hold_right;
`else
        word      = {DW{1'b0}};
        cur_right = {DW{1'b0}};
`endif
      end
      started = 1'b1;
    end else begin
      word = started ? cur_right : {DW{1'b0}};
    end
    exp_slot = {1'b0, word, {(SLOT_BITS - 1 - DW){1'b0}}};
    cap = {SLOT_BITS{1'b0}};
    for (int k = 0; k < SLOT_BITS; k++) begin
      @(posedge aud_bclk);
      cap = {cap[SLOT_BITS-2:0], aud_dacdat};
    end
    if (epoch == rst_epoch) begin
      check_eq(is_left ? "left_slot" : "right_slot", cap, exp_slot);
      check_eq("underflow", 32'(underflow), 32'(model_uf));
    end
  end

  // Push one pair in the middle of a bit period, well away from LRCK edges
  task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(posedge aud_bclk);
    @(negedge clk);
    check_eq("write_ready", 32'(dac_bus.write_ready), 32'(q_left.size() < DEPTH));
    dac_bus.write           = 1'b1;
    dac_bus.writedata_left  = l;
    dac_bus.writedata_right = r;
    if (q_left.size() < DEPTH) begin
      q_left.push_back(l);
      q_right.push_back(r);
    end
    @(negedge clk);
    dac_bus.write = 1'b0;
    check_eq("fifo_count", 32'(fifo_count), 32'(q_left.size()));
  endtask

  // Push timed to land in the very cycle the LRCK fall is recognised (3rd clk edge)
  task automatic push_at_pop(input logic [DW-1:0] l, input logic [DW-1:0] r);
    @(negedge aud_lrck);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    dac_bus.write           = 1'b1;
    dac_bus.writedata_left  = l;
    dac_bus.writedata_right = r;
    q_left.push_back(l);
    q_right.push_back(r);
    @(negedge clk);
    dac_bus.write = 1'b0;
    check_eq("simul_count", 32'(fifo_count), 32'(3));
    check_eq("simul_model", 32'(q_left.size()), 32'(3));
  endtask

  // Two-cycle reset pulse; outputs must clear immediately
  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    rst_epoch++;
    q_left.delete();
    q_right.delete();
    started    = 1'b0;
    model_uf   = 1'b0;
    hold_left  = {DW{1'b0}};
    hold_right = {DW{1'b0}};
    cur_right  = {DW{1'b0}};
    #1;
    check_eq("rst_dacdat", 32'(aud_dacdat), 32'(0));
    check_eq("rst_count", 32'(fifo_count), 32'(0));
    check_eq("rst_underflow", 32'(underflow), 32'(0));
    check_eq("rst_ready", 32'(dac_bus.write_ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #1800000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  logic [DW-1:0] l_v;
  logic [DW-1:0] r_v;

  // Main stimulus sequence
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_epoch  = 0;
    started    = 1'b0;
    model_uf   = 1'b0;
    hold_left  = {DW{1'b0}};
    hold_right = {DW{1'b0}};
    cur_right  = {DW{1'b0}};
    frames_on  = 1'b0;
    reset_n    = 1'b0;
    dac_bus.write           = 1'b0;
    dac_bus.writedata_left  = {DW{1'b0}};
    dac_bus.writedata_right = {DW{1'b0}};

    repeat (3) @(negedge clk);
    check_eq("reset_dacdat", 32'(aud_dacdat), 32'(0));
    check_eq("reset_count", 32'(fifo_count), 32'(0));
    check_eq("reset_underflow", 32'(underflow), 32'(0));
    check_eq("reset_ready", 32'(dac_bus.write_ready), 32'(1));
    reset_n = 1'b1;
    @(negedge clk);

    // Nine back-to-back pushes with no frames running; the first pair is the
    // directed 0x800001 / 0x7FFFFE pattern
    for (int i = 0; i < 9; i++) begin
      if (i == 0) begin
        l_v = 24'h800001;
        r_v = 24'h7FFFFE;
      end else begin
        l_v = DW'($urandom);
        r_v = DW'($urandom);
      end
      check_eq("fill_ready", 32'(dac_bus.write_ready), 32'(q_left.size() < DEPTH));
      dac_bus.write           = 1'b1;
      dac_bus.writedata_left  = l_v;
      dac_bus.writedata_right = r_v;
      if (q_left.size() < DEPTH) begin
        q_left.push_back(l_v);
        q_right.push_back(r_v);
      end
      @(negedge clk);
    end
    dac_bus.write = 1'b0;
    check_eq("full_count", 32'(fifo_count), 32'(DEPTH));
    check_eq("full_ready", 32'(dac_bus.write_ready), 32'(0));

    // Drain all eight pairs, then run into underflow
    frames_on = 1'b1;
    for (int f = 0; f < 10; f++) begin
      @(negedge aud_lrck);
      @(posedge aud_bclk);
      @(negedge clk);
      check_eq("drain_count", 32'(fifo_count), 32'(q_left.size()));
    end

    // Random traffic: 0..2 pushes per frame during the right slot
    for (int f = 0; f < 10; f++) begin
      @(posedge aud_lrck);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        push_pair(DW'($urandom), DW'($urandom));
      end
    end

    // Bring occupancy to exactly 3, then push in the pop cycle
    @(posedge aud_lrck);
    for (int f = 0; f < 12 && q_left.size() > 3; f++) @(posedge aud_lrck);
    while (q_left.size() < 3) push_pair(DW'($urandom), DW'($urandom));
    push_at_pop(DW'($urandom), DW'($urandom));

    // Drain, then send an all-ones pair and reset in the middle of its left slot
    @(posedge aud_lrck);
    for (int f = 0; f < 12 && q_left.size() > 0; f++) @(posedge aud_lrck);
    push_pair(24'hFFFFFF, 24'hFFFFFF);
    @(negedge aud_lrck);
    repeat (6) @(posedge aud_bclk);
    @(negedge clk);
    check_eq("pre_reset_dacdat", 32'(aud_dacdat), 32'(1));
    pulse_reset();

    // After reset, output must stay silent until the next LRCK fall
    @(posedge aud_lrck);
    push_pair(DW'($urandom), DW'($urandom));
    push_pair(DW'($urandom), DW'($urandom));
    repeat (3) @(negedge aud_lrck);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 24: sample width per channel.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two ≥2: number of stereo pairs buffered.
REQ-003 clk  input  1  system clock (CLOCK_50 domain).
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 write  input  1  push request for one stereo pair.
REQ-006 writedata_left  input  DATA_WIDTH  left sample, two's complement.
REQ-007 writedata_right  input  DATA_WIDTH  right sample, two's complement.
REQ-008 write_ready  output  1  FIFO can accept a pair this cycle.
REQ-009 AUD_BCLK  input  1  codec bit clock, asynchronous to clk.
REQ-010 AUD_DACLRCK  input  1  codec DAC frame clock: low = left, high = right.
REQ-011 AUD_DACDAT  output  1  serial DAC data, I2S format.
REQ-012 fifo_count  output  log2(FIFO_DEPTH)+1  stereo pairs currently stored.
REQ-013 underflow  output  1  sticky flag: a frame started with the FIFO empty.

Function
REQ-014 AUD_BCLK and AUD_DACLRCK SHALL each pass through an identical 2-flop synchronizer plus one edge-detect register; a BCLK fall and an LRCK edge are recognised exactly 3 clk after the pin transition.
REQ-015 write_ready SHALL equal (fifo_count < FIFO_DEPTH), computed from registered state.
REQ-016 A push SHALL occur on every clk edge with write=1 and write_ready=1; write while write_ready=0 SHALL be ignored with no state change.
REQ-017 A pop SHALL occur on a recognised LRCK falling edge (start of left slot) when fifo_count>0; the popped pair loads the shift register (left) and the right staging register.
REQ-018 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-019 A recognised LRCK rising edge SHALL load the shift register from the right staging register.
REQ-020 State machine: IDLE (reset; drive 0 and wait for the first LRCK falling edge) -> DELAY (slot loaded; I2S one-bit delay) -> SHIFT (bits MSB first) -> PAD (drive 0) -> DELAY on the next LRCK edge.
REQ-021 DELAY -> SHIFT on the first recognised BCLK fall after the slot load; that fall SHALL drive the MSB on AUD_DACDAT and set bit_cnt=1.
REQ-022 In SHIFT, each recognised BCLK fall SHALL drive the next lower bit; after DATA_WIDTH bits, the next fall SHALL drive 0 and enter PAD.
REQ-023 An LRCK edge and a BCLK fall recognised in the same cycle: the LRCK edge wins and that BCLK fall counts as the delay slot.
REQ-024 An LRCK edge arriving before DATA_WIDTH bits have been sent SHALL truncate the slot and reload (DELAY); no error is flagged.
REQ-025 An LRCK falling edge with fifo_count=0 SHALL set underflow=1 and load the fallback pair (REQ-030); no pop occurs and fifo_count is unchanged.
REQ-026 AUD_DACDAT SHALL be driven from a flop and SHALL change only in cycles where a BCLK fall is recognised.

Reset
REQ-027 reset_n=0 SHALL asynchronously clear pointers, fifo_count, shift and staging registers, bit_cnt and underflow, force AUD_DACDAT=0, and select IDLE; write_ready becomes 1.
REQ-028 Reset asserted mid-slot SHALL abandon the slot and discard buffered pairs; after release, output SHALL restart only at the next LRCK falling edge.
REQ-029 The synchronizer flops SHALL also reset to 0; the edge detect SHALL NOT recognise an edge in the first cycle after release.

Configuration
REQ-030 With macro DAC_UNDERFLOW_HOLD_EN defined, the fallback pair on underflow SHALL be the most recently popped pair (0/0 if none since reset); without it, the fallback pair SHALL be 0/0.

Verification
REQ-031 Push L=0x800001, R=0x7FFFFE, then run BCLK=3.072 MHz, LRCK=48 kHz -> left slot serialises 1000...0001 MSB first, starting one BCLK after the LRCK fall; right slot serialises 0111...1110; fifo_count 1->0.
REQ-032 Push 9 pairs back-to-back with no frames -> write_ready drops after the 8th push, 9th is ignored, fifo_count=8.
REQ-033 Push and pop in the same cycle with fifo_count=3 -> fifo_count stays 3 and data order is preserved.
REQ-034 Empty FIFO at an LRCK fall -> underflow=1 and slot bits all 0 (macro off) or a repeat of the last pair (macro on).
REQ-035 Assert reset_n=0 for 2 cycles mid-left-slot -> AUD_DACDAT=0 immediately, fifo_count=0, underflow=0, and no data until the next LRCK fall.
